// File: rtl/dcol_pkg.sv
// Shared types and constants for the double-column readout controller.
// Optional feature macro: DCOL_ADDR_FILTER_EN (drop invalid encoder codes).
package dcol_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT_Q,
    WRITE,
    CLR
  } state_e;

  localparam int DCOL_ID_W = 4;
  localparam int ADDR_W    = 15;
  localparam int QADDR_W   = 19;

  localparam logic [ADDR_W-1:0] INVALID_ADDR = 15'h7FFF;

endpackage

// File: rtl/dcol_reader.sv
// Reads pixel hits from one dcol priority encoder into the readout queue.
// Define DCOL_ADDR_FILTER_EN to drop the all-ones (invalid) encoder code.
module dcol_reader #(
  parameter logic [3:0] DCOL_ID        = 4'd0,
  parameter int          ADDR_W         = 15,
  parameter int          RESETPE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              empty,
  input  logic              full,
  input  logic [ADDR_W-1:0] addrin,
  output logic              readin,
  output logic [ADDR_W+3:0] addrout,
  output logic              write_q,
  output logic              resetpe
);

  import dcol_pkg::*;

  localparam logic [1:0] CNT_INIT = 2'(RESETPE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W+3:0] addrout_q, addrout_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              readin_q, readin_d;
  logic              write_q_q, write_q_d;
  logic              resetpe_q, resetpe_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    addrout_d = addrout_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel && !empty) state_d = READ;
      end
      READ: begin
        addr_d  = addrin;
        state_d = WAIT_Q;
      end
      WAIT_Q: begin
        if (!full) begin
          state_d = WRITE;
`ifdef DCOL_ADDR_FILTER_EN
          if (addr_q == ADDR_W'(INVALID_ADDR)) state_d = CLR;
`endif
        end
      end
      WRITE: begin
        state_d = CLR;
      end
      CLR: begin
        if (cnt_q == 2'd0) state_d = IDLE;
        else cnt_d = cnt_q - 2'd1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they follow the state being entered
    if (state_d == WRITE) addrout_d = {DCOL_ID, addr_q};
    if (state_d == CLR && state_q != CLR) cnt_d = CNT_INIT;

    readin_d  = (state_d == READ);
    write_q_d = (state_d == WRITE);
    resetpe_d = (state_d == CLR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      addrout_q <= '0;
      cnt_q     <= '0;
      readin_q  <= 1'b0;
      write_q_q <= 1'b0;
      resetpe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      addrout_q <= addrout_d;
      cnt_q     <= cnt_d;
      readin_q  <= readin_d;
      write_q_q <= write_q_d;
      resetpe_q <= resetpe_d;
    end
  end

  assign readin  = readin_q;
  assign write_q = write_q_q;
  assign resetpe = resetpe_q;
  assign addrout = addrout_q;

endmodule

// File: tb/tb_dcol_reader.sv
// Directed plus randomized bench for dcol_reader.
// Honors DCOL_ADDR_FILTER_EN the same way the design does.
module tb_dcol_reader;

  localparam logic [3:0] ID  = 4'h9;
  localparam int         RPE = 2;
`ifdef DCOL_ADDR_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        empty;
  logic        full;
  logic [14:0] addrin;
  logic        readin;
  logic [18:0] addrout;
  logic        write_q;
  logic        resetpe;

  int          checks = 0;
  int          errors = 0;
  logic [18:0] last_out;

  dcol_reader #(
    .DCOL_ID       (ID),
    .ADDR_W        (15),
    .RESETPE_CYCLES(RPE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .empty  (empty),
    .full   (full),
    .addrin (addrin),
    .readin (readin),
    .addrout(addrout),
    .write_q(write_q),
    .resetpe(resetpe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One hit from IDLE; expected timeline derived from cycle arithmetic.
  task automatic do_hit(input logic [14:0] a, input int nfull);
    bit wr;
    int wc;
    int cs;
    int e;
    wr = !(FILT && a == 15'h7FFF);
    wc = 3 + nfull;
    cs = wr ? wc + 1 : wc;
    e  = cs + RPE;
    sel    = 1'b1;
    empty  = 1'b0;
    full   = 1'b0;
    addrin = a;
    for (int c = 1; c <= e; c++) begin
      tick();
      if (wr && c == wc) last_out = {ID, a};
      chk("ctl", {29'd0, readin, write_q, resetpe},
          {29'd0, c == 1, wr && c == wc, c >= cs && c < cs + RPE});
      chk("addrout", {13'd0, addrout}, {13'd0, last_out});
      if (c >= 2) begin
        addrin = 15'($urandom);
        sel    = 1'($urandom);
        empty  = 1'($urandom);
        if (c < 2 + nfull) full = 1'b1;
        else if (c == 2 + nfull) full = 1'b0;
        else full = 1'($urandom);
      end
    end
    sel   = 1'b0;
    empty = 1'b1;
    full  = 1'b0;
  endtask

  task automatic idle_run(input int n);
    for (int i = 0; i < n; i++) begin
      sel    = 1'($urandom);
      empty  = sel ? 1'b1 : 1'($urandom);
      full   = 1'($urandom);
      addrin = 15'($urandom);
      tick();
      chk("idle_ctl", {29'd0, readin, write_q, resetpe}, 32'd0);
      chk("idle_addr", {13'd0, addrout}, {13'd0, last_out});
    end
    sel   = 1'b0;
    empty = 1'b1;
    full  = 1'b0;
  endtask

  initial begin
    logic [14:0] ra;
    reset    = 1'b0;
    sel      = 1'b0;
    empty    = 1'b1;
    full     = 1'b0;
    addrin   = '0;
    last_out = '0;
    #1;
    chk("rst_ctl", {29'd0, readin, write_q, resetpe}, 32'd0);
    chk("rst_addr", {13'd0, addrout}, 32'd0);
    #22 reset = 1'b1;
    tick();

    idle_run(20);

    do_hit(15'h00A1, 0);
    for (int k = 0; k < 7; k++) do_hit(15'(16'h00A3 + 16'(2 * k)), 0);

    do_hit(15'h0123, 5);

    // Abort while parked in WAIT_Q
    sel    = 1'b1;
    empty  = 1'b0;
    full   = 1'b1;
    addrin = 15'h0BAD;
    tick();
    chk("pre_abort_rd", {31'd0, readin}, 32'd1);
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    last_out = '0;
    chk("abort_ctl", {29'd0, readin, write_q, resetpe}, 32'd0);
    chk("abort_addr", {13'd0, addrout}, 32'd0);
    sel   = 1'b0;
    empty = 1'b1;
    full  = 1'b0;
    #3 reset = 1'b1;
    tick();
    chk("post_abort", {29'd0, readin, write_q, resetpe}, 32'd0);
    do_hit(15'h0BAD, 0);

    do_hit(15'h7FFF, 0);
    do_hit(15'h0456, 1);
    do_hit(15'h7FFF, 2);

    for (int t = 0; t < 30; t++) begin
      ra = ($urandom_range(0, 7) == 0) ? 15'h7FFF : 15'($urandom);
      do_hit(ra, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle_run(int'($urandom_range(1, 4)));
    end

    idle_run(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
